// File: rtl/cpu_pkg.sv
// Common CPU-wide widths shared by the pipeline stage registers.
package cpu_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_W      = 5;
    localparam int MEMTOREG_W = 2;
endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: one-cycle capture of EX results and control,
// with flush turning the captured instruction into a bubble.
module ex_mem
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EX_Flush,
    input  logic                  RegWrite_in,
    input  logic [MEMTOREG_W-1:0] MemtoReg_in,
    input  logic                  Branch_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic                  Jump_in,
    input  logic [DATA_W-1:0]     jump_addr_in,
    input  logic [DATA_W-1:0]     branch_addr_in,
    input  logic                  ALU_zero_in,
    input  logic [DATA_W-1:0]     ALU_result_in,
    input  logic [DATA_W-1:0]     reg_read_data_2_in,
    input  logic [REG_W-1:0]      ID_EX_RegisterRd_in,
    output logic                  RegWrite_out,
    output logic [MEMTOREG_W-1:0] MemtoReg_out,
    output logic                  Branch_out,
    output logic                  MemRead_out,
    output logic                  MemWrite_out,
    output logic                  Jump_out,
    output logic [DATA_W-1:0]     jump_addr_out,
    output logic [DATA_W-1:0]     branch_addr_out,
    output logic                  ALU_zero_out,
    output logic [DATA_W-1:0]     ALU_result_out,
    output logic [DATA_W-1:0]     reg_read_data_2_out,
    output logic [REG_W-1:0]      EX_MEM_RegisterRd_out
);
    localparam int CTRL_W = MEMTOREG_W + 5;

    logic [CTRL_W-1:0] w_ctrl_in;
    logic [CTRL_W-1:0] w_ctrl_d;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_jump_addr;
    logic [DATA_W-1:0] r_branch_addr;
    logic              r_alu_zero;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_rd2;
    logic [REG_W-1:0]  r_rd;

    assign w_ctrl_in = {RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Jump_in};
    // A flushed instruction keeps its data but loses every side effect.
    assign w_ctrl_d  = EX_Flush ? '0 : w_ctrl_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl        <= '0;
            r_jump_addr   <= '0;
            r_branch_addr <= '0;
            r_alu_zero    <= 1'b0;
            r_alu_result  <= '0;
            r_rd2         <= '0;
            r_rd          <= '0;
        end else begin
            r_ctrl        <= w_ctrl_d;
            r_jump_addr   <= jump_addr_in;
            r_branch_addr <= branch_addr_in;
            r_alu_zero    <= ALU_zero_in;
            r_alu_result  <= ALU_result_in;
            r_rd2         <= reg_read_data_2_in;
            r_rd          <= ID_EX_RegisterRd_in;
        end
    end

    assign {RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, Jump_out} = r_ctrl;
    assign jump_addr_out         = r_jump_addr;
    assign branch_addr_out       = r_branch_addr;
    assign ALU_zero_out          = r_alu_zero;
    assign ALU_result_out        = r_alu_result;
    assign reg_read_data_2_out   = r_rd2;
    assign EX_MEM_RegisterRd_out = r_rd;
endmodule

// File: tb/tb_ex_mem.sv
// Directed and randomized checks of the EX/MEM pipeline register against a
// bundle-level reference of its capture rules.
module tb_ex_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic EX_Flush = 1'b0;

    // Input bundle: {RegWrite, MemtoReg[1:0], Branch, MemRead, MemWrite, Jump,
    //                jump_addr, branch_addr, ALU_zero, ALU_result, rd2, Rd}
    logic [140:0] in_v = '0;

    logic        RegWrite_in, Branch_in, MemRead_in, MemWrite_in, Jump_in, ALU_zero_in;
    logic [1:0]  MemtoReg_in;
    logic [31:0] jump_addr_in, branch_addr_in, ALU_result_in, reg_read_data_2_in;
    logic [4:0]  ID_EX_RegisterRd_in;

    logic        RegWrite_out, Branch_out, MemRead_out, MemWrite_out, Jump_out, ALU_zero_out;
    logic [1:0]  MemtoReg_out;
    logic [31:0] jump_addr_out, branch_addr_out, ALU_result_out, reg_read_data_2_out;
    logic [4:0]  EX_MEM_RegisterRd_out;
    logic [140:0] out_v;

    assign {RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Jump_in,
            jump_addr_in, branch_addr_in, ALU_zero_in, ALU_result_in,
            reg_read_data_2_in, ID_EX_RegisterRd_in} = in_v;
    assign out_v = {RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, Jump_out,
                    jump_addr_out, branch_addr_out, ALU_zero_out, ALU_result_out,
                    reg_read_data_2_out, EX_MEM_RegisterRd_out};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem dut (
        .clk(clk), .rst(rst), .EX_Flush(EX_Flush),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Jump_in(Jump_in),
        .jump_addr_in(jump_addr_in), .branch_addr_in(branch_addr_in),
        .ALU_zero_in(ALU_zero_in), .ALU_result_in(ALU_result_in),
        .reg_read_data_2_in(reg_read_data_2_in), .ID_EX_RegisterRd_in(ID_EX_RegisterRd_in),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .Branch_out(Branch_out),
        .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .Jump_out(Jump_out),
        .jump_addr_out(jump_addr_out), .branch_addr_out(branch_addr_out),
        .ALU_zero_out(ALU_zero_out), .ALU_result_out(ALU_result_out),
        .reg_read_data_2_out(reg_read_data_2_out), .EX_MEM_RegisterRd_out(EX_MEM_RegisterRd_out)
    );

    function automatic logic [140:0] mk(input logic [6:0] ctrl, input logic [31:0] ja,
                                        input logic [31:0] ba, input logic z,
                                        input logic [31:0] alu, input logic [31:0] rd2,
                                        input logic [4:0] rd);
        return {ctrl, ja, ba, z, alu, rd2, rd};
    endfunction

    // Reference capture rule: reset clears all, flush clears the control group only.
    function automatic logic [140:0] model(input logic [140:0] v, input logic r, input logic f);
        logic [140:0] e;
        e = v;
        if (f) e[140:134] = 7'd0;
        if (r) e = '0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [140:0] obs, input logic [140:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [140:0] exp_v;
        logic [140:0] held;

        // Reset with every input non-zero
        rst = 1'b1; EX_Flush = 1'b0; in_v = '1;
        step();
        chk("reset_all", out_v, '0);
        chk("reset_alu", 141'(ALU_result_out), 141'(0));
        chk("reset_rd", 141'(EX_MEM_RegisterRd_out), 141'(0));

        // Pass-through, and nothing visible before the edge
        rst = 1'b0;
        in_v = mk(7'b0000010, 32'h0, 32'h0, 1'b0, 32'h12345678, 32'hDEADBEEF, 5'd17);
        #2;
        chk("pass_before_edge", out_v, '0);
        step();
        chk("pass_alu", 141'(ALU_result_out), 141'(32'h12345678));
        chk("pass_rd2", 141'(reg_read_data_2_out), 141'(32'hDEADBEEF));
        chk("pass_rd", 141'(EX_MEM_RegisterRd_out), 141'(5'd17));
        chk("pass_memwrite", 141'(MemWrite_out), 141'(1'b1));
        chk("pass_all", out_v, in_v);

        // Single-cycle flush then normal capture
        in_v = mk(7'b1101111, 32'h0, 32'h00400010, 1'b0, 32'h0, 32'h0, 5'd0);
        EX_Flush = 1'b1;
        step();
        chk("flush_ctrl", 141'(out_v[140:134]), 141'(0));
        chk("flush_branch_addr", 141'(branch_addr_out), 141'(32'h00400010));
        EX_Flush = 1'b0;
        step();
        chk("after_flush_ctrl", 141'(out_v[140:134]), 141'(7'b1101111));
        chk("after_flush_memtoreg", 141'(MemtoReg_out), 141'(2'b10));

        // Reset asserted mid-cycle takes effect only at the edge
        held = out_v;
        rst = 1'b1;
        #2;
        chk("rst_sync_hold", out_v, held);
        // Reset together with flush
        EX_Flush = 1'b1;
        in_v = mk(7'b1111111, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 32'hCAFEF00D, 32'h0BADBEEF, 5'd9);
        step();
        chk("rst_and_flush", out_v, '0);

        // Capture resumes immediately after reset drops
        rst = 1'b0; EX_Flush = 1'b0;
        step();
        chk("post_reset_capture", out_v, in_v);

        // Random stream with one flush pulse at cycle 5
        for (int i = 0; i < 2000; i++) begin
            in_v = mk(7'($urandom_range(0, 127)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                      $urandom, $urandom, 5'($urandom_range(0, 31)));
            EX_Flush = (i == 5);
            exp_v = model(in_v, 1'b0, EX_Flush);
            step();
            chk($sformatf("rand_%0d", i), out_v, exp_v);
        end
        EX_Flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_mem.md
# ex_mem

EX/MEM pipeline register of the five-stage CPU pipeline, between the execute (EX) and memory (MEM) stages. On each rising clock edge it captures the EX-stage control signals, branch and jump targets, ALU outputs, store data and destination register number. It presents them to MEM for exactly one cycle. A flush input squashes the captured instruction by zeroing its control signals, so the result is a bubble.

## Interface
Parameters: none. Widths are fixed at 32-bit data/address, 5-bit register number and 2-bit MemtoReg.

Ports, in positional order (instantiation is positional):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- EX_Flush  in  1  squash the instruction being captured this edge
- RegWrite_in  in  1  register-file write enable
- MemtoReg_in  in  2  write-back source select
- Branch_in  in  1  branch instruction
- MemRead_in  in  1  data-memory read
- MemWrite_in  in  1  data-memory write
- Jump_in  in  1  jump instruction
- jump_addr_in  in  32  jump target
- branch_addr_in  in  32  branch target
- ALU_zero_in  in  1  ALU zero flag
- ALU_result_in  in  32  ALU result / memory address
- reg_read_data_2_in  in  32  store data (rt value)
- ID_EX_RegisterRd_in  in  5  destination register number
- RegWrite_out  out  1
- MemtoReg_out  out  2
- Branch_out  out  1
- MemRead_out  out  1
- MemWrite_out  out  1
- Jump_out  out  1
- jump_addr_out  out  32
- branch_addr_out  out  32
- ALU_zero_out  out  1
- ALU_result_out  out  32
- reg_read_data_2_out  out  32
- EX_MEM_RegisterRd_out  out  5

Each *_out is the registered copy of the like-named *_in. EX_MEM_RegisterRd_out is the registered copy of ID_EX_RegisterRd_in.

## Operation
- Control group: RegWrite, MemtoReg, Branch, MemRead, MemWrite, Jump.
- Data group: jump_addr, branch_addr, ALU_zero, ALU_result, reg_read_data_2, RegisterRd.
- Every rising clk edge, priority order:
  - rst=1: all outputs, both groups, become 0.
  - else EX_Flush=1: all control-group outputs become 0. Data-group outputs capture their inputs normally.
  - else: all outputs capture their inputs.
- The register has no enable and no stall; it loads every cycle.
- There is no combinational path from any input to any output. Outputs are driven directly from flops.

## Timing
- Latency is exactly 1 cycle. Inputs are sampled at edge N and are visible on the outputs after edge N until edge N+1.
- Reset is synchronous. Asserting rst between edges does not change the outputs until the next rising edge.
  - The cycle after rst deasserts, normal capture resumes with no extra dead cycle.
- EX_Flush affects only the edge at which it is sampled high. For a 1-cycle pulse, exactly one bubble is produced.
  - The next edge, with EX_Flush=0, captures normally.
- rst and EX_Flush high together: reset wins and all outputs are 0.
- Power-up state before the first reset is undefined (X). Benches must apply rst or tolerate X until the first capture.

## Structure
- Put the shared widths in the project's common CPU package, as constants: data/address width 32, register-number width 5, MemtoReg width 2.
  - Do not create a package local to this block.
- Flush masking is implemented as a single mux on the control-group D inputs.
- No sub-module is needed. Implement as one module, ex_mem, with a single clocked always block.

## Test plan
- Reset: drive every input to non-zero (RegWrite=1, MemtoReg=2'b11, Branch/MemRead/MemWrite/Jump=1, all 32-bit fields 32'hFFFFFFFF, Rd=5'd31) with rst=1 -> after the edge, every output is 0.
- Pass-through: rst=0, EX_Flush=0, ALU_result_in=32'h12345678, reg_read_data_2_in=32'hDEADBEEF, Rd=5'd17, MemWrite=1 -> the same values appear on the outputs after one edge, and not before it.
- Flush: EX_Flush=1 for one cycle with all controls=1, MemtoReg=2'b10, branch_addr_in=32'h00400010 -> control outputs are 0, branch_addr_out=32'h00400010. On the next edge, with EX_Flush=0, the controls propagate again.
- Reset vs flush: rst=1 and EX_Flush=1 together with non-zero inputs -> all outputs are 0.
- Random stream: ~2000 cycles of random inputs, flush pulsed at cycle 5 -> each output equals its input from the previous cycle. Exception: the control outputs are 0 for the single flushed capture.
